// File: rtl/adrv9001_serdes_pack.sv
// rtl/adrv9001_serdes_pack.sv - ADRV9001 receive SSI packer: strobe alignment, I/Q word assembly, lock monitor
module adrv9001_serdes_pack #(
  parameter int LOCK_ERR_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  strb_in,
  input  logic [7:0]  i_in,
  input  logic [7:0]  q_in,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        locked,
  output logic [2:0]  align_offset,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] ERR_MAX = 4'(LOCK_ERR_MAX);

  state_t      state, state_nxt;
  logic [7:0]  s_b0, s_b1, s_b2;
  logic [7:0]  i_b0, i_b1, i_b2;
  logic [7:0]  q_b0, q_b1, q_b2;
  logic [23:0] w_s, w_i, w_q;
  logic        phase, phase_nxt;
  logic [3:0]  consec, consec_nxt;
  logic [15:0] err_nxt;
  logic [2:0]  offset_nxt;
  logic [31:0] tdata_nxt;
  logic        tvalid_nxt;
  logic        err_inc;
  logic [7:0]  match;
  logic        hit;
  logic [2:0]  hit_k;
  logic        cur_match;

  // 16-bit word whose MSB sits at window index 16+k
  function automatic logic [15:0] pick(input logic [23:0] w, input logic [2:0] k);
    pick = w[{2'b10, k} -: 16];
  endfunction

  assign w_s = {s_b2, s_b1, s_b0};
  assign w_i = {i_b2, i_b1, i_b0};
  assign w_q = {q_b2, q_b1, q_b0};

  always_comb begin
    match = '0;
    hit   = 1'b0;
    hit_k = 3'd0;
    for (int k = 0; k < 8; k++) begin
      match[k] = (pick(w_s, 3'(k)) == 16'h8000);
    end
    // later iterations win, so the highest matching offset is taken
    for (int k = 0; k < 8; k++) begin
      if (match[k]) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  assign cur_match = match[align_offset];

  always_comb begin
    state_nxt  = state;
    phase_nxt  = ~phase;
    consec_nxt = consec;
    offset_nxt = align_offset;
    tdata_nxt  = m_axis_tdata;
    tvalid_nxt = 1'b0;
    err_inc    = 1'b0;
    if (!enable) begin
      state_nxt  = SEARCH;
      phase_nxt  = 1'b0;
      consec_nxt = 4'd0;
    end else begin
      case (state)
        SEARCH: begin
          phase_nxt = 1'b0;
          if (hit) begin
            offset_nxt = hit_k;
            state_nxt  = CONFIRM;
          end
        end
        CONFIRM: begin
          if (phase) begin
            if (cur_match) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = {pick(w_i, align_offset), pick(w_q, align_offset)};
              state_nxt  = LOCKED;
            end else begin
              err_inc   = 1'b1;
              state_nxt = SEARCH;
            end
          end
        end
        LOCKED: begin
          if (phase) begin
            if (cur_match) begin
              tvalid_nxt = 1'b1;
              tdata_nxt  = {pick(w_i, align_offset), pick(w_q, align_offset)};
              consec_nxt = 4'd0;
            end else begin
              err_inc = 1'b1;
              if (consec == ERR_MAX - 4'd1) begin
                state_nxt  = SEARCH;
                consec_nxt = 4'd0;
              end else begin
                consec_nxt = consec + 4'd1;
              end
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end
    err_nxt = (err_inc && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_b0 <= '0; s_b1 <= '0; s_b2 <= '0;
      i_b0 <= '0; i_b1 <= '0; i_b2 <= '0;
      q_b0 <= '0; q_b1 <= '0; q_b2 <= '0;
    end else begin
      s_b0 <= strb_in; s_b1 <= s_b0; s_b2 <= s_b1;
      i_b0 <= i_in;    i_b1 <= i_b0; i_b2 <= i_b1;
      q_b0 <= q_in;    q_b1 <= q_b0; q_b2 <= q_b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEARCH;
      phase         <= 1'b0;
      consec        <= 4'd0;
      align_offset  <= 3'd0;
      err_cnt       <= 16'd0;
      m_axis_tdata  <= 32'd0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      consec        <= consec_nxt;
      align_offset  <= offset_nxt;
      err_cnt       <= err_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_adrv9001_serdes_pack.sv
// tb/tb_adrv9001_serdes_pack.sv - bench for adrv9001_serdes_pack
module tb_adrv9001_serdes_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  strb_in, i_in, q_in;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        locked;
  logic [2:0]  align_offset;
  logic [15:0] err_cnt;

  adrv9001_serdes_pack #(.LOCK_ERR_MAX(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .strb_in(strb_in), .i_in(i_in), .q_in(q_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .locked(locked), .align_offset(align_offset), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  k;
    logic [15:0] i0;
    logic [15:0] step;
    bit          qinv;
    logic [15:0] q0;
    logic [2:0]  exp_off;
    logic [31:0] exp_first;
  } scen_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit sq[$], iq[$], qq[$];
  int mq[$];
  bit          gen_on = 1'b0;
  int          gen_idx;
  logic [15:0] gen_i0, gen_step, gen_q0;
  bit          gen_qinv;
  int          bad_from, bad_to, slip_at, slip_bits;
  logic [15:0] bad_strb;
  int          msb_edge[512];
  logic [31:0] got[$];
  int          got_cyc[$];
  int          fall_cyc;
  logic        prev_locked = 1'b0;

  function automatic logic [31:0] sample(input int j);
    logic [15:0] iv, qv;
    iv = gen_i0 + 16'(j) * gen_step;
    qv = gen_qinv ? ~iv : gen_q0;
    return {iv, qv};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] s, input logic [15:0] iv, input logic [15:0] qv, input int idx);
    for (int b = 15; b >= 0; b--) begin
      sq.push_back(s[b]);
      iq.push_back(iv[b]);
      qq.push_back(qv[b]);
      mq.push_back((b == 15) ? idx : -1);
    end
  endtask

  task automatic push_zero_bits(input int n);
    for (int b = 0; b < n; b++) begin
      sq.push_back(1'b0); iq.push_back(1'b0); qq.push_back(1'b0); mq.push_back(-1);
    end
  endtask

  task automatic drive_next();
    logic [7:0]  s, iv, qv;
    logic [15:0] sw;
    logic [31:0] smp;
    int m;
    while (gen_on && sq.size() < 24) begin
      if (gen_idx == slip_at) push_zero_bits(slip_bits);
      sw  = (gen_idx >= bad_from && gen_idx <= bad_to) ? bad_strb : 16'h8000;
      smp = sample(gen_idx);
      push_word(sw, smp[31:16], smp[15:0], gen_idx);
      gen_idx++;
    end
    s = '0; iv = '0; qv = '0;
    for (int b = 7; b >= 0; b--) begin
      if (sq.size() > 0) begin
        s[b]  = sq.pop_front();
        iv[b] = iq.pop_front();
        qv[b] = qq.pop_front();
        m = mq.pop_front();
        if (m >= 0 && m < 512) msb_edge[m] = cyc + 1;
      end
    end
    strb_in = s; i_in = iv; q_in = qv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (m_axis_tvalid) begin
      got.push_back(m_axis_tdata);
      got_cyc.push_back(cyc);
    end
    if (prev_locked && !locked) fall_cyc = cyc;
    prev_locked = locked;
    drive_next();
  endtask

  task automatic flush();
    gen_on = 1'b0;
    sq.delete(); iq.delete(); qq.delete(); mq.delete();
    got.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    flush();
    strb_in = '0; i_in = '0; q_in = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_gen(input logic [2:0] k, input logic [15:0] i0, input logic [15:0] step,
                           input bit qinv, input logic [15:0] q0);
    flush();
    gen_i0 = i0; gen_step = step; gen_qinv = qinv; gen_q0 = q0;
    gen_idx = 0;
    bad_from = -1; bad_to = -2; bad_strb = 16'h8000;
    slip_at = -1; slip_bits = 0;
    for (int j = 0; j < 512; j++) msb_edge[j] = -100;
    push_zero_bits(7 - int'(k));
    gen_on = 1'b1;
    drive_next();
  endtask

  initial begin
    scen_t tbl[4];
    bit    ok;
    int    pos, cidx, cnt_v, cnt_l, snap;

    tbl[0] = '{3'd7, 16'h1234, 16'h0000, 1'b0, 16'hABCD, 3'd7, 32'h1234ABCD};
    tbl[1] = '{3'd3, 16'h0001, 16'h0001, 1'b1, 16'h0000, 3'd3, 32'h0002FFFD};
    tbl[2] = '{3'd0, 16'hFFFE, 16'h0101, 1'b0, 16'h5A5A, 3'd0, 32'h00FF5A5A};
    tbl[3] = '{3'd5, 16'h8000, 16'h1000, 1'b1, 16'h0000, 3'd5, 32'h90006FFF};

    rst = 1'b1; enable = 1'b1; strb_in = '0; i_in = '0; q_in = '0;
    do_reset();
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_offset", {29'd0, align_offset}, 32'd0);
    chk("rst_err", {16'd0, err_cnt}, 32'd0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      start_gen(tbl[t].k, tbl[t].i0, tbl[t].step, tbl[t].qinv, tbl[t].q0);
      repeat (40) tick();
      chk($sformatf("s%0d_locked", t), {31'd0, locked}, 32'd1);
      chk($sformatf("s%0d_offset", t), {29'd0, align_offset}, {29'd0, tbl[t].exp_off});
      chk($sformatf("s%0d_err", t), {16'd0, err_cnt}, 32'd0);
      chk($sformatf("s%0d_first", t), (got.size() > 0) ? got[0] : 32'hDEAD_DEAD, tbl[t].exp_first);
      chk($sformatf("s%0d_latency", t), (got_cyc.size() > 0) ? 32'(got_cyc[0]) : 32'hFFFF_FFFF,
          32'(msb_edge[1] + 3));
      ok = (got.size() >= 14);
      for (int j = 0; j < got.size(); j++) begin
        if (got[j] !== sample(j + 1)) ok = 1'b0;
        if (j > 0 && got_cyc[j] - got_cyc[j-1] != 2) ok = 1'b0;
      end
      chk($sformatf("s%0d_sequence", t), {31'd0, ok}, 32'd1);
    end

    // single strobe glitch while locked
    do_reset();
    start_gen(3'd3, 16'h0100, 16'h0001, 1'b1, 16'h0000);
    repeat (20) tick();
    cidx = gen_idx + 1;
    bad_from = cidx; bad_to = cidx; bad_strb = 16'hC000;
    got.delete(); got_cyc.delete();
    repeat (24) tick();
    chk("glitch_err", {16'd0, err_cnt}, 32'd1);
    chk("glitch_locked", {31'd0, locked}, 32'd1);
    pos = -1;
    ok = 1'b1;
    for (int j = 0; j < got.size(); j++) begin
      if (got[j] === sample(cidx - 1)) pos = j;
      if (got[j] === sample(cidx)) ok = 1'b0;
    end
    chk("glitch_dropped", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    if (pos >= 0 && pos + 1 < got.size()) begin
      if (got[pos+1] === sample(cidx + 1)) ok = 1'b1;
    end
    chk("glitch_next", {31'd0, ok}, 32'd1);

    // loss of strobe for 3 samples, then restore shifted to k=5
    do_reset();
    start_gen(3'd7, 16'h4000, 16'h0003, 1'b0, 16'h3C3C);
    repeat (20) tick();
    cidx = gen_idx;
    bad_from = cidx; bad_to = cidx + 2; bad_strb = 16'h0000;
    slip_at = cidx + 3; slip_bits = 2;
    fall_cyc = -1;
    got.delete(); got_cyc.delete();
    repeat (30) tick();
    chk("loss_fall_edge", 32'(fall_cyc), 32'(msb_edge[cidx+2] + 3));
    chk("loss_err", {16'd0, err_cnt}, 32'd3);
    chk("loss_relocked", {31'd0, locked}, 32'd1);
    chk("loss_offset", {29'd0, align_offset}, 32'd5);
    pos = -1;
    for (int j = got.size() - 1; j >= 0; j--) begin
      if (got_cyc[j] > fall_cyc) pos = j;
    end
    chk("loss_first_after", (pos >= 0) ? got[pos] : 32'hDEAD_DEAD, sample(cidx + 4));

    // enable low for 10 cycles mid-stream
    snap = int'(err_cnt);
    enable = 1'b0;
    tick();
    chk("en_locked_drop", {31'd0, locked}, 32'd0);
    chk("en_tvalid_drop", {31'd0, m_axis_tvalid}, 32'd0);
    cnt_v = 0; cnt_l = 0;
    repeat (9) begin
      tick();
      if (m_axis_tvalid) cnt_v++;
      if (locked) cnt_l++;
    end
    chk("en_no_tvalid", 32'(cnt_v), 32'd0);
    chk("en_no_locked", 32'(cnt_l), 32'd0);
    enable = 1'b1;
    got.delete(); got_cyc.delete();
    repeat (30) tick();
    chk("en_relocked", {31'd0, locked}, 32'd1);
    chk("en_err_held", {16'd0, err_cnt}, 32'(snap));
    chk("en_offset", {29'd0, align_offset}, 32'd5);
    chk("en_outputs", {31'd0, got.size() >= 8}, 32'd1);

    // asynchronous reset mid-cycle while locked
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tdata", m_axis_tdata, 32'd0);
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_offset", {29'd0, align_offset}, 32'd0);
    chk("arst_err", {16'd0, err_cnt}, 32'd0);
    flush();
    strb_in = '0; i_in = '0; q_in = '0;
    tick();
    rst = 1'b0;
    cnt_v = 0; cnt_l = 0;
    repeat (20) begin
      tick();
      if (m_axis_tvalid) cnt_v++;
      if (locked) cnt_l++;
    end
    chk("idle_no_tvalid", 32'(cnt_v), 32'd0);
    chk("idle_no_locked", 32'(cnt_l), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adrv9001_serdes_pack.md
# adrv9001_serdes_pack

Receive-side SSI packer for the ADRV9001/2 LVDS interface, in the `dclk_div` domain between the three receive 1:8 SERDES lanes (strobe, I, Q) and the user AXI-stream. It searches the strobe lane for the sample boundary and locks to the bit offset within the SERDES byte. It then assembles 16-bit I and Q words into 32-bit samples and monitors strobe integrity. It drops lock after repeated framing errors.

## Interface
- `LOCK_ERR_MAX`, default 3: number of consecutive strobe mismatches in LOCKED that forces a return to SEARCH. Legal range is 1–15.
- `clk` in 1: `dclk_div`. This is the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: packer enable, already synchronous to `clk`. Low means a synchronous clear to SEARCH.
- `strb_in` in 8: strobe lane parallel byte. Bit 7 is the earliest in time.
- `i_in` in 8: I lane parallel byte. Bit 7 is the earliest.
- `q_in` in 8: Q lane parallel byte. Bit 7 is the earliest.
- `m_axis_tdata` out 32: {I[15:0], Q[15:0]}.
- `m_axis_tvalid` out 1: one-cycle sample strobe. There is no backpressure and no tready.
- `locked` out 1: high in LOCKED.
- `align_offset` out 3: locked bit offset k.
- `err_cnt` out 16: saturating count of strobe mismatches.

## Operation
- Line format: 16 bits per sample per lane, MSB first. The strobe lane is 1 only during the I/Q MSB bit, so the strobe word is 16'h8000.
- Input pipeline: on every clk edge, b2<=b1, b1<=b0, b0<=in. This applies to all three lanes.
- Window W = {b2,b1,b0}, 24 bits. Index 23 is the oldest bit.
- Candidate offset k (0..7) is the index of a 1 in the strobe bits of b2. W index 16+k is the sample MSB.
- Extraction: I = Wi[16+k -: 16] and Q = Wq[16+k -: 16].
- Strobe check: match(k) is true when Ws[16+k -: 16] == 16'h8000.
- States:
  - SEARCH: each cycle, take the highest k with a 1 in the b2 strobe bits and match(k). On a hit, latch k into `align_offset`, go to CONFIRM, and clear the phase toggle. No output is produced for the hit sample.
  - CONFIRM: evaluate exactly 2 cycles after the hit, at the same k.
    - Match: output the sample and go to LOCKED.
    - Mismatch: increment `err_cnt` and go to SEARCH.
  - LOCKED: evaluate every 2nd cycle; the phase toggle alternates starting from the CONFIRM evaluation.
    - Match: output the sample and clear the consecutive-error counter.
    - Mismatch: no output, increment `err_cnt` and the consecutive-error counter. When the consecutive count reaches `LOCK_ERR_MAX`, go to SEARCH and clear the counter.
- Non-evaluation cycles: `m_axis_tvalid`=0 and `m_axis_tdata` holds its value.
- `enable`=0: the next edge forces SEARCH, `locked`=0, `m_axis_tvalid`=0, and clears the consecutive counter and phase. The b0..b2 pipeline keeps shifting. `err_cnt` and `align_offset` hold.
- `err_cnt` saturates at 16'hFFFF and is cleared only by `rst`.

## Timing
- Reset values: `m_axis_tdata`=0, `m_axis_tvalid`=0, `locked`=0, `align_offset`=0, `err_cnt`=0. State is SEARCH and all of b0..b2 are 0.
- Reset takes effect immediately and asynchronously at any point, including mid-sample. After release, alignment restarts from SEARCH.
- Latency: the byte containing a sample's MSB bit is sampled at edge N. The matching `m_axis_tvalid`/`m_axis_tdata` are registered at edge N+3.
- Steady state: one `m_axis_tvalid` every 2 cycles. `locked` rises on the same edge as the first `m_axis_tvalid`.
- `locked` falls on the edge where the `LOCK_ERR_MAX`-th consecutive mismatch is evaluated, or on the edge after `enable` falls.
- Lock timing: the earliest first output is 2 cycles after the SEARCH hit.
- Simultaneous events: `enable`=0 overrides any evaluation in the same cycle. A mismatch that also saturates `err_cnt` still drives the state transition.

## Test plan
- Reset: assert `rst` mid-stream. All outputs go to 0 immediately. After release with no strobe applied, `locked` stays 0 and `m_axis_tvalid` never asserts.
- Aligned stream (k=7): repeat I=16'h1234, Q=16'hABCD. Require `locked`=1, `align_offset`=7, and `m_axis_tdata`=32'h1234ABCD with `m_axis_tvalid` every 2 cycles. The first output must arrive 3 edges after the MSB byte.
- Bit-slipped stream (k=3): use incrementing I and Q=~I. Require `align_offset`=3, outputs in order with no skips, and `err_cnt`=0.
- Single strobe glitch while LOCKED: corrupt the strobe word of one sample to 16'hC000. Require that sample dropped, `err_cnt`=1, `locked` stays 1, and the next sample is output.
- Loss of strobe: zero the strobe lane for 3 samples with `LOCK_ERR_MAX`=3. Require `locked`=0 at the 3rd evaluation and `err_cnt`=3. When the strobe is restored at k=5, require re-lock with `align_offset`=5.
- `enable` low for 10 cycles mid-stream: require `m_axis_tvalid`=0 and `locked`=0 from the next edge. When `enable` returns high, require re-lock through SEARCH and CONFIRM, and `err_cnt` unchanged.
